// File: rtl/booth_radix4_multiplier_if.sv
`default_nettype none
// ============================================================================
// Module      : booth_radix4_multiplier_if
// Description : Operand/result bundle between the control unit (master) and
//               the radix-4 Booth multiplier (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface booth_radix4_multiplier_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic             busy;
    logic             done;
    logic [2:0]       digit;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, digit, hi, lo
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, digit, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/booth_radix4_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : booth_radix4_multiplier
// Description : Sequential signed radix-4 (bit-pair) Booth multiplier. One
//               recoded digit per RUN cycle; 2*WIDTH-bit product on hi/lo.
//               Optional macro BOOTH_EARLY_EXIT_EN: finish as soon as every
//               remaining digit is zero.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_radix4_multiplier #(
    parameter int WIDTH = 32
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    booth_radix4_multiplier_if.slave  bus
);
    localparam int DIGITS = WIDTH / 2;
    localparam int CNT_W  = $clog2(DIGITS) + 1;
    localparam int AW     = WIDTH + 2;          // accumulator with two guard bits
    localparam int CW     = 2 * WIDTH + 3;      // {A, Q, q_-1}
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [WIDTH-1:0]       r_m;
    logic [WIDTH-1:0]       r_q;
    logic signed [AW-1:0]   r_a;
    logic                   r_qm1;
    logic [CNT_W-1:0]       r_count;
    logic                   r_busy;
    logic                   r_done;
    logic [WIDTH-1:0]       r_hi;
    logic [WIDTH-1:0]       r_lo;

    logic [2:0]             w_triplet;
    logic [2:0]             w_booth;
    logic signed [AW-1:0]   w_mag;
    logic signed [AW-1:0]   w_pp;
    logic signed [AW-1:0]   w_sum;
    logic signed [CW-1:0]   w_cat;
    logic signed [CW-1:0]   w_next;
    logic signed [CW-1:0]   w_step;
    logic                   w_last;
    logic [2:0]             w_digit;

    assign w_triplet = {r_q[1:0], r_qm1};

    // Bit-pair recoding of the current triplet into a sign-magnitude digit
    always_comb begin
        w_booth = 3'b000;
        case (w_triplet)
            3'b001, 3'b010: w_booth = 3'b001;
            3'b011:         w_booth = 3'b010;
            3'b100:         w_booth = 3'b110;
            3'b101, 3'b110: w_booth = 3'b101;
            default:        w_booth = 3'b000;
        endcase
    end

    // Digit decode: magnitude selects 0/M/2M, sign bit negates; magnitude 11
    // never occurs and falls to zero
    always_comb begin
        w_mag = '0;
        case (w_booth[1:0])
            2'b01:   w_mag = {{2{r_m[WIDTH-1]}}, r_m};
            2'b10:   w_mag = {r_m[WIDTH-1], r_m, 1'b0};
            default: w_mag = '0;
        endcase
        w_pp = w_booth[2] ? -w_mag : w_mag;
    end

    assign w_sum  = r_a + w_pp;
    assign w_cat  = {w_sum, r_q, r_qm1};
    assign w_next = w_cat >>> 2;

`ifdef BOOTH_EARLY_EXIT_EN
    logic [WIDTH-1:0]       w_rem_mask;
    logic                   w_exit;
    logic [CNT_W-1:0]       w_remaining;
    logic signed [CW-1:0]   w_hold;
    logic signed [CW-1:0]   w_exit_val;

    // Unprocessed multiplier bits sit in the low WIDTH-2*count bits of r_q;
    // if they and q_-1 are uniform, every remaining digit recodes to zero
    assign w_rem_mask  = {WIDTH{1'b1}} >> {r_count, 1'b0};
    assign w_exit      = (((r_q & w_rem_mask) == '0) && !r_qm1) ||
                         (((r_q | ~w_rem_mask) == {WIDTH{1'b1}}) && r_qm1);
    assign w_remaining = CNT_W'(DIGITS) - r_count;
    assign w_hold      = {r_a, r_q, r_qm1};
    assign w_exit_val  = w_hold >>> {w_remaining, 1'b0};
    assign w_step      = w_exit ? w_exit_val : w_next;
    assign w_last      = w_exit || (r_count == C_LAST);
    assign w_digit     = w_exit ? 3'b000 : w_booth;
`else
    assign w_step      = w_next;
    assign w_last      = (r_count == C_LAST);
    assign w_digit     = w_booth;
`endif

    // Control FSM with datapath registers; product latched on entry to DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_m     <= '0;
            r_q     <= '0;
            r_a     <= '0;
            r_qm1   <= 1'b0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_m     <= bus.multiplicand;
                        r_q     <= bus.multiplier;
                        r_a     <= '0;
                        r_qm1   <= 1'b0;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a     <= w_step[CW-1:WIDTH+1];
                    r_q     <= w_step[WIDTH:1];
                    r_qm1   <= w_step[0];
                    r_count <= r_count + 1'b1;
                    if (w_last) begin
                        r_hi    <= w_step[2*WIDTH:WIDTH+1];
                        r_lo    <= w_step[WIDTH:1];
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.digit = (r_state == S_RUN) ? w_digit : 3'b000;
    assign bus.hi    = r_hi;
    assign bus.lo    = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_booth_radix4_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_radix4_multiplier
// Description : Self-checking bench for booth_radix4_multiplier: directed
//               vector table, ignored-start and mid-run reset sequences, and
//               random signed operand pairs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_radix4_multiplier;
    localparam int W = 32;
`ifdef BOOTH_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    booth_radix4_multiplier_if #(.WIDTH(W)) bus ();

    booth_radix4_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] m;
        logic [W-1:0] q;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        bit           chk_d;
        logic [2:0]   d0;
        logic [2:0]   d1;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected done cycle (relative to the accepting edge) from the multiplier
    function automatic int exp_lat(input logic [W-1:0] q);
        int  u = W/2 - 1;
        bit  found = 1'b0;
        for (int i = 0; i < W/2; i++) begin
            logic qm1;
            bit   uni;
            qm1 = 1'b0;
            if (i > 0) qm1 = q[2*i-1];
            uni = 1'b1;
            for (int b = 2*i; b < W; b++) if (q[b] !== qm1) uni = 1'b0;
            if (uni && !found) begin
                u = i;
                found = 1'b1;
            end
        end
        return EE ? (u + 2) : (W/2 + 1);
    endfunction

    function automatic logic [63:0] ref_prod(input logic [W-1:0] m, input logic [W-1:0] q);
        logic signed [63:0] sm, sq;
        sm = $signed(m);
        sq = $signed(q);
        return sm * sq;
    endfunction

    // One operation: start accepted at edge T; k counts cycles after T
    task automatic do_op(input logic [W-1:0] m, input logic [W-1:0] q,
                         output int done_k, output int busy_n, output logic done_after,
                         output logic [63:0] prod, output logic [2:0] d0,
                         output logic [2:0] d1, output logic [2:0] d_done);
        int k;
        @(negedge clk);
        bus.start = 1'b1;
        bus.multiplicand = m;
        bus.multiplier = q;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.multiplicand = ~m;
        bus.multiplier = ~q;
        done_k = 0; busy_n = 0; k = 0; d0 = 3'bx; d1 = 3'bx; d_done = 3'bx;
        while (k < 60 && done_k == 0) begin
            @(negedge clk);
            k++;
            if (bus.busy) busy_n++;
            if (k == 1) d0 = bus.digit;
            if (k == 2) d1 = bus.digit;
            if (bus.done) begin
                done_k = k;
                d_done = bus.digit;
            end
        end
        prod = {bus.hi, bus.lo};
        @(negedge clk);
        done_after = bus.done;
    endtask

    initial begin
        int dk, bn, lat, k, ndone;
        logic da;
        logic [63:0] p;
        logic [2:0] d0, d1, dd;
        logic [W-1:0] m, q;
        logic [W-1:0] corner[5];

        //                m             q             hi            lo            chk_d d0      d1
        vecs[0]  = '{32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1, 3'b001, 3'b101};
        vecs[1]  = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 3'b000, 3'b000};
        vecs[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b1, 3'b101, 3'b000};
        vecs[3]  = '{32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000, 1'b0, 3'b000, 3'b000};
        vecs[4]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 3'b000, 3'b000};
        vecs[5]  = '{32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 32'h80000000, 1'b0, 3'b000, 3'b000};
        vecs[6]  = '{32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 3'b000, 3'b000};
        vecs[7]  = '{32'h12345678, 32'h00000002, 32'h00000000, 32'h2468ACF0, 1'b0, 3'b000, 3'b000};
        vecs[8]  = '{32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 3'b000, 3'b000};
        vecs[9]  = '{32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 3'b000, 3'b000};
        vecs[10] = '{32'h0000FFFF, 32'h0000FFFF, 32'h00000000, 32'hFFFE0001, 1'b0, 3'b000, 3'b000};
        vecs[11] = '{32'hFFFFFFFB, 32'h7FFFFFFF, 32'hFFFFFFFD, 32'h80000005, 1'b0, 3'b000, 3'b000};
        vecs[12] = '{32'd5,        32'd3,        32'h00000000, 32'h0000000F, 1'b1, 3'b101, 3'b001};
        vecs[13] = '{32'd5,        32'd0,        32'h00000000, 32'h00000000, 1'b1, 3'b000, 3'b000};

        reset = 1'b1;
        bus.start = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy",  {63'd0, bus.busy}, 64'd0);
        chk("reset_done",  {63'd0, bus.done}, 64'd0);
        chk("reset_digit", {61'd0, bus.digit}, 64'd0);
        chk("reset_hilo",  {bus.hi, bus.lo}, 64'd0);
        reset = 1'b0;

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            do_op(vecs[i].m, vecs[i].q, dk, bn, da, p, d0, d1, dd);
            lat = exp_lat(vecs[i].q);
            chk($sformatf("vec%0d_product", i), p, {vecs[i].hi, vecs[i].lo});
            chk($sformatf("vec%0d_latency", i), 64'(dk), 64'(lat));
            chk($sformatf("vec%0d_busy_width", i), 64'(bn), 64'(lat - 1));
            chk($sformatf("vec%0d_done_width", i), {63'd0, da}, 64'd0);
            chk($sformatf("vec%0d_digit_done", i), {61'd0, dd}, 64'd0);
            if (vecs[i].chk_d) begin
                chk($sformatf("vec%0d_digit0", i), {61'd0, d0}, {61'd0, vecs[i].d0});
                chk($sformatf("vec%0d_digit1", i), {61'd0, d1}, {61'd0, vecs[i].d1});
            end
        end
        chk("latency_q3_value",  64'(exp_lat(32'd3)), EE ? 64'd4 : 64'd17);
        chk("latency_q0_value",  64'(exp_lat(32'd0)), EE ? 64'd2 : 64'd17);

        // Start pulsed again at T+5 must be ignored; exactly one done
        @(negedge clk);
        bus.start = 1'b1;
        bus.multiplicand = 32'd7;
        bus.multiplier = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        ndone = 0; dk = 0;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            bus.start = (k == 5);
            if (k == 5) begin
                bus.multiplicand = 32'h11111111;
                bus.multiplier = 32'h22222222;
            end
            if (bus.done) begin
                ndone++;
                if (dk == 0) begin
                    dk = k;
                    chk("ignored_start_product", {bus.hi, bus.lo}, ref_prod(32'd7, 32'hA5A5A5A5));
                end
            end
        end
        bus.start = 1'b0;
        chk("ignored_start_done_cycle", 64'(dk), 64'd17);
        chk("ignored_start_done_count", 64'(ndone), 64'd1);
        chk("ignored_start_hold", {bus.hi, bus.lo}, ref_prod(32'd7, 32'hA5A5A5A5));

        // Reset asserted mid-RUN at T+8, new start at T+10
        @(negedge clk);
        bus.start = 1'b1;
        bus.multiplicand = 32'd9;
        bus.multiplier = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 7) chk("midrun_busy", {63'd0, bus.busy}, 64'd1);
            if (k == 8) reset = 1'b1;
        end
        @(negedge clk);
        chk("midrun_reset_busy",  {63'd0, bus.busy}, 64'd0);
        chk("midrun_reset_done",  {63'd0, bus.done}, 64'd0);
        chk("midrun_reset_digit", {61'd0, bus.digit}, 64'd0);
        chk("midrun_reset_hilo",  {bus.hi, bus.lo}, 64'd0);
        reset = 1'b0;
        do_op(32'hDEADBEEF, 32'hA5A5A5A5, dk, bn, da, p, d0, d1, dd);
        chk("after_reset_product", p, ref_prod(32'hDEADBEEF, 32'hA5A5A5A5));
        chk("after_reset_latency", 64'(dk), 64'd17);

        // Random signed pairs with corner values mixed in
        corner[0] = 32'h00000000; corner[1] = 32'h00000001; corner[2] = 32'hFFFFFFFF;
        corner[3] = 32'h7FFFFFFF; corner[4] = 32'h80000000;
        for (int r = 0; r < 1000; r++) begin
            m = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            q = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            do_op(m, q, dk, bn, da, p, d0, d1, dd);
            lat = exp_lat(q);
            chk($sformatf("rand%0d_product m=%h q=%h", r, m, q), p, ref_prod(m, q));
            chk($sformatf("rand%0d_latency", r), 64'(dk), 64'(lat));
            chk($sformatf("rand%0d_busy_width", r), 64'(bn), 64'(lat - 1));
            chk($sformatf("rand%0d_done_width", r), {63'd0, da}, 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
